// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one MSB-first parallel-in/serial-out path among NREQ requesters.
// Latency: first serial bit in the cycle after the grant edge; word period WIDTH+2 (WIDTH+3 with parity).
// Backpressure: requests are sampled only in IDLE; a requester waits, holding req, until its one-cycle ack.
// Optional feature: define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx_scheduler #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 3,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] din,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy,
    output logic                  sdata,
    output logic                  sdata_valid,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH);

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]  ack_q, ack_d;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             found_hi, found_lo;
    logic [IDW-1:0]   hi_idx, lo_idx, win_idx;
    logic [WIDTH-1:0] win_word;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall (wrap-around).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !found_hi && (IDW'(i) >= rr_q)) begin
                found_hi = 1'b1;
                hi_idx   = IDW'(i);
            end
            if (req[i] && !found_lo) begin
                found_lo = 1'b1;
                lo_idx   = IDW'(i);
            end
        end
        win_idx = found_hi ? hi_idx : lo_idx;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_word = din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: capture the winner in IDLE, shift in SHIFT, one-cycle DONE gap.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found_lo) begin
                    shift_d = win_word;
                    cnt_d   = '0;
                    gnt_d   = win_idx;
                    ack_d   = NREQ'(1) << win_idx;
                    rr_d    = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^win_word;
`endif
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
`ifdef PISO_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            S_PARITY: state_d = S_DONE;
`endif
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any word in flight and re-homes the pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Outputs decoded from registered state only, so they drop with reset immediately.
    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        sdata_valid = 1'b0;
        sdata       = 1'b0;
        if (state_q == S_SHIFT) begin
            sdata_valid = 1'b1;
            sdata       = shift_q[WIDTH-1];
        end
`ifdef PISO_TX_PARITY_EN
        if (state_q == S_PARITY) begin
            sdata_valid = 1'b1;
            sdata       = par_q;
        end
`endif
    end

    assign ack    = ack_q;
    assign gnt_id = gnt_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: directed word table, hand-written corner sequences, random run vs reference model.
// Latency: checks first bit one cycle after the grant edge and the WIDTH+2 (or +3) word period.
// Backpressure: requests raised while busy must wait for IDLE and the rotated pointer.
module tb_piso_tx_scheduler;

    localparam int W = 4;
    localparam int N = 3;
`ifdef PISO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N*W-1:0] din;
    logic [N-1:0] ack;
    logic [1:0]   gnt_id;
    logic         busy, sdata, sdata_valid, done;

    int n_cmp = 0;
    int n_bad = 0;

    piso_tx_scheduler #(.WIDTH(W), .NREQ(N), .IDW(2)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .gnt_id(gnt_id),
        .busy(busy), .sdata(sdata), .sdata_valid(sdata_valid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] din;
        logic [1:0]     gnt;
        logic [W-1:0]   word;
    } vec_t;

    vec_t tbl[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one request set in IDLE, then check ack, grant, serial stream, done and the idle gap.
    task automatic run_word(input logic [N-1:0] r, input logic [N*W-1:0] d,
                            input logic [1:0] g, input logic [W-1:0] word);
        logic [W-1:0] got;
        logic [N-1:0] one;
        int vcnt;
        got  = '0;
        vcnt = 0;
        one  = 3'b001 << g;
        req  = r;
        din  = d;
        step();
        chk("ack", ack, one);
        chk("gnt_id", gnt_id, g);
        for (int i = 0; i < W; i++) begin
            if (i > 0) step();
            got = {got[W-2:0], sdata};
            if (sdata_valid && busy) vcnt++;
        end
        chk("word", got, word);
        chk("valid_cycles", vcnt, W);
        if (PAR != 0) begin
            step();
            chk("parity", {sdata_valid, sdata}, {1'b1, ^word});
        end
        step();
        chk("done_cycle", {done, sdata_valid, busy, ack}, {3'b101, 3'b000});
        step();
        chk("gap_cycle", {done, busy, ack}, 5'b0);
    endtask

    // Reference model state for the random phase.
    logic [8:0] q[$];
    int         m_rr, m_last;

    function automatic logic [8:0] frame(input logic [N-1:0] a, input int g,
                                         input logic b, input logic s, input logic v, input logic dn);
        logic [1:0] gg;
        gg = g[1:0];
        return {a, gg, b, s, v, dn};
    endfunction

    task automatic model_grant(input logic [N-1:0] r, input logic [N*W-1:0] d);
        int w;
        logic [W-1:0] word;
        logic [N-1:0] one;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_rr + k) % N;
            if (w < 0 && r[i]) w = i;
        end
        word = d[w*W +: W];
        one  = 3'b001 << w;
        for (int b = 0; b < W; b++)
            q.push_back(frame((b == 0) ? one : 3'b000, w, 1'b1, word[W-1-b], 1'b1, 1'b0));
        if (PAR != 0) q.push_back(frame(3'b000, w, 1'b1, ^word, 1'b1, 1'b0));
        q.push_back(frame(3'b000, w, 1'b1, 1'b0, 1'b0, 1'b1));
        q.push_back(frame(3'b000, w, 1'b0, 1'b0, 1'b0, 1'b0));
        m_rr   = (w + 1) % N;
        m_last = w;
    endtask

    initial begin
        logic [W-1:0] got;
        logic [8:0]   expf;

        tbl[0] = '{3'b111, {4'hF, 4'h5, 4'hA}, 2'd0, 4'hA};
        tbl[1] = '{3'b111, {4'hF, 4'h5, 4'hA}, 2'd1, 4'h5};
        tbl[2] = '{3'b111, {4'hF, 4'h5, 4'hA}, 2'd2, 4'hF};
        tbl[3] = '{3'b111, {4'hF, 4'h5, 4'hA}, 2'd0, 4'hA};
        tbl[4] = '{3'b001, {4'hF, 4'h5, 4'hB}, 2'd0, 4'hB};
        tbl[5] = '{3'b100, {4'h9, 4'h5, 4'hB}, 2'd2, 4'h9};
        tbl[6] = '{3'b110, {4'h9, 4'h6, 4'hB}, 2'd1, 4'h6};
        tbl[7] = '{3'b011, {4'h9, 4'h6, 4'h3}, 2'd0, 4'h3};

        // Reset held with all requests pending: everything quiet, no grant.
        rst = 1'b0;
        req = 3'b111;
        din = '0;
        #2;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("reset_outputs", {ack, gnt_id, busy, sdata, sdata_valid, done}, 9'd0);
        end
        rst = 1'b1;

        // Directed word table: contention rotation, wrap-around and single requests.
        for (int v = 0; v < 8; v++)
            run_word(tbl[v].req, tbl[v].din, tbl[v].gnt, tbl[v].word);

        // Request while busy: req2 raised during req0's word must wait for IDLE.
        req = 3'b001;
        din = {4'hC, 4'h0, 4'hB};
        step();
        chk("busy_req_ack0", ack, 3'b001);
        got = {3'b000, sdata};
        req = 3'b000;
        step();
        req = 3'b100;
        got = {got[W-2:0], sdata};
        chk("busy_req_no_ack", ack, 3'b000);
        for (int i = 2; i < W; i++) begin
            step();
            got = {got[W-2:0], sdata};
        end
        chk("busy_req_word0", got, 4'hB);
        repeat (PAR + 1) step();
        chk("busy_req_done", done, 1'b1);
        step();
        chk("busy_req_gap", {busy, ack}, 4'b0);
        step();
        chk("busy_req_ack2", {ack, gnt_id}, {3'b100, 2'd2});
        req = 3'b000;
        repeat (W - 1 + PAR + 2) step();

        // Reset mid-word: outputs drop at once, no done, pointer back to 0.
        req = 3'b001;
        din = {4'h0, 4'h0, 4'hB};
        step();
        req = 3'b000;
        step();
        rst = 1'b0;
        #1;
        chk("midreset_quiet", {busy, sdata_valid, sdata, ack}, 6'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midreset_no_done", {done, busy}, 2'b0);
        end
        rst = 1'b1;
        req = 3'b011;
        step();
        chk("midreset_regrant", {ack, gnt_id}, {3'b001, 2'd0});
        req = 3'b000;
        repeat (W - 1 + PAR + 2) step();
        chk("midreset_idle", busy, 1'b0);

        // Random phase against the reference model, from a fresh reset.
        rst = 1'b0;
        step();
        rst = 1'b1;
        m_rr   = 0;
        m_last = 0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            req = 3'($urandom_range(0, 7));
            din = 12'($urandom);
            if (q.size() == 0 && req != 3'b000) model_grant(req, din);
            step();
            if (q.size() != 0) expf = q.pop_front();
            else expf = frame(3'b000, m_last, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("random", {ack, gnt_id, busy, sdata, sdata_valid, done}, expf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
